// File: rtl/ahb_timer_if.sv
// AHB-Lite slave-side signal bundle for the timer; master drives the request,
// slave returns ready/response/read data.
interface ahb_timer_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_timer.sv
// Zero-wait-state AHB-Lite timer: 64-bit mtime/mtimecmp behind a prescaler,
// with a registered level interrupt for the core.
module ahb_timer #(
  parameter int PRE_W  = 16,
  parameter int ADDR_W = 5
) (
  input  logic       HCLK,
  input  logic       HRESET,
  ahb_timer_if.slave bus,
  output logic       irq_timer
);
  localparam int OFF_W = ADDR_W - 2;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      3'd0:    m = 4'b0001 << a;
      3'd1:    if (!a[0]) m = a[1] ? 4'b1100 : 4'b0011;
      3'd2:    if (a == 2'd0) m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] din,
                                              input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

  logic                  accept;
  logic                  vld_p0;
  logic                  wr_p0;
  logic [OFF_W-1:0]      off_p0;
  logic [3:0]            mask_p0;
  logic [2**OFF_W-1:0]   wsel;
  logic                  en;
  logic                  irq_en;
  logic [PRE_W-1:0]      prescale;
  logic [PRE_W-1:0]      pcnt;
  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic                  tick;
  logic [31:0]           rdata;
  logic                  unused_bits;

  assign accept      = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign unused_bits = ^{bus.HADDR[31:ADDR_W], bus.HTRANS[0]};

  // Address phase -> data phase
  always_ff @(posedge HCLK) begin
    if (HRESET) vld_p0 <= 1'b0;
    else        vld_p0 <= accept;
  end

  always_ff @(posedge HCLK) begin
    if (accept) begin
      off_p0  <= bus.HADDR[ADDR_W-1:2];
      mask_p0 <= lane_mask(bus.HSIZE, bus.HADDR[1:0]);
      wr_p0   <= bus.HWRITE;
    end
  end

  // One-hot register write strobe; an empty lane mask writes nothing
  always_comb begin
    wsel = '0;
    if (vld_p0 && wr_p0 && (mask_p0 != 4'd0)) wsel[off_p0] = 1'b1;
  end

  assign tick = en & (pcnt == prescale);

  // Data phase: register writes, prescaler and timebase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      en        <= 1'b0;
      irq_en    <= 1'b0;
      prescale  <= '0;
      pcnt      <= '0;
      mtime     <= 64'd0;
      mtimecmp  <= '1;
      irq_timer <= 1'b0;
    end else begin
      if (wsel[0] && mask_p0[0]) begin
        en     <= bus.HWDATA[0];
        irq_en <= bus.HWDATA[1];
      end
      if (wsel[1]) begin
        for (int i = 0; i < PRE_W; i++)
          if (mask_p0[i/8]) prescale[i] <= bus.HWDATA[i];
      end

      if (wsel[1] || tick) pcnt <= '0;
      else if (en)         pcnt <= pcnt + 1'b1;

      // A software write to either mtime half wins over the tick increment
      if (wsel[2] || wsel[3])
        mtime <= {wsel[3] ? merge_lanes(mtime[63:32], bus.HWDATA, mask_p0) : mtime[63:32],
                  wsel[2] ? merge_lanes(mtime[31:0],  bus.HWDATA, mask_p0) : mtime[31:0]};
      else if (tick)
        mtime <= mtime + 64'd1;

      if (wsel[4]) mtimecmp[31:0]  <= merge_lanes(mtimecmp[31:0],  bus.HWDATA, mask_p0);
      if (wsel[5]) mtimecmp[63:32] <= merge_lanes(mtimecmp[63:32], bus.HWDATA, mask_p0);

      irq_timer <= irq_en & (mtime >= mtimecmp);
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (vld_p0) begin
      case (off_p0)
        3'd0:    rdata = {30'd0, irq_en, en};
        3'd1:    rdata = {{(32-PRE_W){1'b0}}, prescale};
        3'd2:    rdata = mtime[31:0];
        3'd3:    rdata = mtime[63:32];
        3'd4:    rdata = mtimecmp[31:0];
        3'd5:    rdata = mtimecmp[63:32];
        3'd6:    rdata = {31'd0, (mtime >= mtimecmp)};
        default: rdata = 32'd0;
      endcase
    end
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;
endmodule

// File: tb/tb_ahb_timer.sv
// Bench for ahb_timer: constant-vector table, hand-built timing sequences and
// randomized bus traffic against a transaction-level reference model.
module tb_ahb_timer;
  logic HCLK = 1'b0;
  logic HRESET;
  logic irq_timer;
  logic hready_drv = 1'b1;
  ahb_timer_if bus();

  ahb_timer #(.PRE_W(16), .ADDR_W(5)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus.slave), .irq_timer(irq_timer)
  );

  always #5 HCLK = ~HCLK;

  int vecs = 0;
  int errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_en, m_ie, m_irq, m_pend, m_pwr;
  logic [15:0] m_pre, m_left;
  logic [63:0] m_mt, m_cmp;
  logic [4:0]  m_paddr;
  logic [2:0]  m_psize;
  initial m_pend = 1'b0;

  function automatic logic [3:0] m_lanes(input logic [4:0] a, input logic [2:0] sz);
    logic [3:0] r;
    int nb;
    r = 4'd0;
    if (sz > 3'd2) return r;
    nb = 1 << sz;
    if ((int'(a) % nb) != 0) return r;
    for (int b = 0; b < nb; b++) r[int'(a[1:0]) + b] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] word_of(input logic [2:0] off, input logic en, input logic ie,
                                          input logic [15:0] pre, input logic [63:0] mt,
                                          input logic [63:0] cmp);
    case (off)
      3'd0:    return {30'd0, ie, en};
      3'd1:    return {16'd0, pre};
      3'd2:    return mt[31:0];
      3'd3:    return mt[63:32];
      3'd4:    return cmp[31:0];
      3'd5:    return cmp[63:32];
      3'd6:    return {31'd0, (mt >= cmp)};
      default: return 32'd0;
    endcase
  endfunction

  // Countdown form of the prescaler: m_left = cycles still to wait before a tick
  always @(posedge HCLK) begin : model_b
    logic tick, mw;
    logic [3:0] ln;
    logic [31:0] w;
    logic [2:0] off;
    logic n_en, n_ie;
    logic [15:0] n_pre, n_left;
    logic [63:0] n_mt, n_cmp;
    n_en = m_en; n_ie = m_ie; n_pre = m_pre; n_left = m_left; n_mt = m_mt; n_cmp = m_cmp;
    tick = m_en && (m_left == 16'd0);
    mw = 1'b0;
    if (m_en) n_left = tick ? m_pre : m_left - 16'd1;
    if (m_pend && m_pwr) begin
      ln  = m_lanes(m_paddr, m_psize);
      off = m_paddr[4:2];
      w   = word_of(off, m_en, m_ie, m_pre, m_mt, m_cmp);
      for (int b = 0; b < 4; b++) if (ln[b]) w[8*b +: 8] = bus.HWDATA[8*b +: 8];
      if (ln != 4'd0) begin
        case (off)
          3'd0: begin n_en = w[0]; n_ie = w[1]; end
          3'd1: begin n_pre = w[15:0]; n_left = w[15:0]; end
          3'd2: begin n_mt[31:0] = w; mw = 1'b1; end
          3'd3: begin n_mt[63:32] = w; mw = 1'b1; end
          3'd4: n_cmp[31:0] = w;
          3'd5: n_cmp[63:32] = w;
          default: ;
        endcase
      end
    end
    if (tick && !mw) n_mt = m_mt + 64'd1;
    if (HRESET) begin
      m_en <= 1'b0; m_ie <= 1'b0; m_pre <= 16'd0; m_left <= 16'd0;
      m_mt <= 64'd0; m_cmp <= '1; m_irq <= 1'b0; m_pend <= 1'b0;
    end else begin
      m_en <= n_en; m_ie <= n_ie; m_pre <= n_pre; m_left <= n_left;
      m_mt <= n_mt; m_cmp <= n_cmp;
      m_irq  <= m_ie && (m_mt >= m_cmp);
      m_pend <= bus.HSEL && bus.HTRANS[1] && bus.HREADY;
      m_paddr <= bus.HADDR[4:0];
      m_psize <= bus.HSIZE;
      m_pwr   <= bus.HWRITE;
    end
  end

  // ---------------- bus tasks ----------------
  task automatic cyc(input logic sel, input logic [31:0] a, input logic [2:0] sz,
                     input logic w, input logic [31:0] wd);
    bus.HSEL   = sel;
    bus.HTRANS = sel ? 2'b10 : 2'b00;
    bus.HADDR  = a;
    bus.HSIZE  = sz;
    bus.HWRITE = w;
    bus.HWDATA = wd;
    bus.HREADY = hready_drv;
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [2:0] sz, input logic [31:0] d);
    cyc(1'b1, {27'd0, a}, sz, 1'b1, 32'd0);
    cyc(1'b0, 32'd0, 3'd0, 1'b0, d);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cyc(1'b1, {27'd0, a}, 3'd2, 1'b0, 32'd0);
    d = bus.HRDATA;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    cyc(1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
    cyc(1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
    HRESET = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [2:0]  sz;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [4:0] a, input logic [2:0] sz,
                              input logic [31:0] d, input logic [31:0] exp);
    vec_t v;
    v.w = w; v.a = a; v.sz = sz; v.d = d; v.exp = exp;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[31];
    logic [31:0] v, prev, cur;
    int last, diffs;
    bit found;
    logic sel, w;
    logic [2:0] sz;
    logic [31:0] a, wd, exp;

    tbl[0]  = mk(0, 5'h00, 2, 0, 32'h0);
    tbl[1]  = mk(0, 5'h04, 2, 0, 32'h0);
    tbl[2]  = mk(0, 5'h08, 2, 0, 32'h0);
    tbl[3]  = mk(0, 5'h0C, 2, 0, 32'h0);
    tbl[4]  = mk(0, 5'h10, 2, 0, 32'hFFFFFFFF);
    tbl[5]  = mk(0, 5'h14, 2, 0, 32'hFFFFFFFF);
    tbl[6]  = mk(0, 5'h18, 2, 0, 32'h0);
    tbl[7]  = mk(0, 5'h1C, 2, 0, 32'h0);
    tbl[8]  = mk(1, 5'h11, 0, 32'h0000AB00, 0);
    tbl[9]  = mk(0, 5'h10, 2, 0, 32'hFFFFABFF);
    tbl[10] = mk(1, 5'h12, 1, 32'h12340000, 0);
    tbl[11] = mk(0, 5'h10, 2, 0, 32'h1234ABFF);
    tbl[12] = mk(0, 5'h14, 2, 0, 32'hFFFFFFFF);
    tbl[13] = mk(1, 5'h11, 1, 32'h0, 0);
    tbl[14] = mk(1, 5'h10, 3, 32'h0, 0);
    tbl[15] = mk(0, 5'h10, 2, 0, 32'h1234ABFF);
    tbl[16] = mk(1, 5'h18, 2, 32'h1, 0);
    tbl[17] = mk(0, 5'h18, 2, 0, 32'h0);
    tbl[18] = mk(1, 5'h1C, 2, 32'hFFFFFFFF, 0);
    tbl[19] = mk(0, 5'h1C, 2, 0, 32'h0);
    tbl[20] = mk(1, 5'h04, 2, 32'hFFFF1234, 0);
    tbl[21] = mk(0, 5'h04, 2, 0, 32'h00001234);
    tbl[22] = mk(1, 5'h00, 2, 32'hFFFFFFFE, 0);
    tbl[23] = mk(0, 5'h00, 2, 0, 32'h2);
    tbl[24] = mk(1, 5'h0C, 2, 32'hDEADBEEF, 0);
    tbl[25] = mk(0, 5'h0C, 2, 0, 32'hDEADBEEF);
    tbl[26] = mk(1, 5'h17, 0, 32'h0, 0);
    tbl[27] = mk(0, 5'h18, 2, 0, 32'h1);
    tbl[28] = mk(0, 5'h14, 2, 0, 32'h00FFFFFF);
    tbl[29] = mk(1, 5'h00, 2, 32'h0, 0);
    tbl[30] = mk(0, 5'h00, 2, 0, 32'h0);

    HRESET = 1'b1;
    do_reset();
    check("reset_irq", {31'd0, irq_timer}, 32'd0);
    check("reset_hrdata", bus.HRDATA, 32'd0);
    check("reset_ready_resp", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'h2);

    for (int i = 0; i < 31; i++) begin
      if (tbl[i].w) wr(tbl[i].a, tbl[i].sz, tbl[i].d);
      else begin
        rd(tbl[i].a, v);
        check($sformatf("table_%0d_off%02h", i, tbl[i].a), v, tbl[i].exp);
        check($sformatf("table_%0d_ready", i), {30'd0, bus.HREADYOUT, bus.HRESP}, 32'h2);
      end
    end

    // Prescaler = 3: one tick every 4 cycles
    do_reset();
    wr(5'h04, 2, 32'd3);
    wr(5'h00, 2, 32'd1);
    repeat (40) cyc(1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
    rd(5'h08, v);
    check("prescale_range", {31'd0, (v >= 32'd9 && v <= 32'd10)}, 32'd1);
    check("prescale_model", v, m_mt[31:0]);
    prev = v; last = -1; diffs = 0;
    for (int i = 1; i < 24; i++) begin
      cyc(1'b1, 32'h08, 3'd2, 1'b0, 32'd0);
      cur = bus.HRDATA;
      if (cur != prev) begin
        if (last >= 0) begin
          check("tick_spacing", 32'(i - last), 32'd4);
          diffs++;
        end
        last = i;
      end
      prev = cur;
    end
    check("tick_count", {31'd0, (diffs >= 3)}, 32'd1);

    // 64-bit wrap with carry in the same cycle
    do_reset();
    wr(5'h08, 2, 32'hFFFFFFFF);
    wr(5'h0C, 2, 32'hFFFFFFFF);
    wr(5'h04, 2, 32'd0);
    cyc(1'b1, 32'h00, 3'd2, 1'b1, 32'd0);
    cyc(1'b1, 32'h08, 3'd2, 1'b0, 32'd1);
    check("wrap_lo_before", bus.HRDATA, 32'hFFFFFFFF);
    cyc(1'b1, 32'h0C, 3'd2, 1'b0, 32'd0);
    check("wrap_hi_after1", bus.HRDATA, 32'd0);
    cyc(1'b1, 32'h08, 3'd2, 1'b0, 32'd0);
    check("wrap_lo_after2", bus.HRDATA, 32'd1);
    cyc(1'b1, 32'h0C, 3'd2, 1'b0, 32'd0);
    check("wrap_hi_after3", bus.HRDATA, 32'd0);
    cyc(1'b0, 32'd0, 3'd0, 1'b0, 32'd0);

    // Interrupt rise/fall timing
    do_reset();
    wr(5'h14, 2, 32'd0);
    wr(5'h10, 2, 32'd20);
    wr(5'h04, 2, 32'd0);
    wr(5'h00, 2, 32'd3);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b1, 32'h08, 3'd2, 1'b0, 32'd0);
      v = bus.HRDATA;
      if (v == 32'd20) check("irq_low_at_20", {31'd0, irq_timer}, 32'd0);
      if (v == 32'd21) begin
        check("irq_high_at_21", {31'd0, irq_timer}, 32'd1);
        found = 1'b1;
        break;
      end
    end
    if (!found) check("irq_rise_seen", 32'd0, 32'd1);
    rd(5'h18, v);
    check("status_set", v, 32'd1);
    wr(5'h10, 2, 32'd100);
    check("irq_hold_at_write", {31'd0, irq_timer}, 32'd1);
    cyc(1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
    check("irq_fall", {31'd0, irq_timer}, 32'd0);

    // Write to MTIME_LO on a tick cycle suppresses the increment
    do_reset();
    wr(5'h00, 2, 32'd1);
    repeat (3) cyc(1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
    cyc(1'b1, 32'h08, 3'd2, 1'b1, 32'd0);
    cyc(1'b1, 32'h08, 3'd2, 1'b0, 32'h100);
    check("suppress_readback", bus.HRDATA, 32'h100);
    cyc(1'b1, 32'h08, 3'd2, 1'b0, 32'd0);
    check("suppress_next", bus.HRDATA, 32'h101);
    cyc(1'b0, 32'd0, 3'd0, 1'b0, 32'd0);

    // Reset during a pending write data phase
    cyc(1'b1, 32'h10, 3'd2, 1'b1, 32'd0);
    HRESET = 1'b1;
    cyc(1'b0, 32'd0, 3'd0, 1'b0, 32'h55);
    HRESET = 1'b0;
    rd(5'h10, v);
    check("reset_midwrite_cmp", v, 32'hFFFFFFFF);
    rd(5'h00, v);
    check("reset_midwrite_ctrl", v, 32'd0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      sel = ($urandom_range(0, 3) != 0);
      hready_drv = ($urandom_range(0, 7) != 0);
      a   = $urandom;
      sz  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
      w   = 1'($urandom_range(0, 1));
      if (m_pend && m_pwr && (m_paddr[4:2] <= 3'd1)) wd = $urandom_range(0, 3);
      else wd = $urandom;
      HRESET = ($urandom_range(0, 99) == 0);
      cyc(sel, a, sz, w, wd);
      HRESET = 1'b0;
      exp = m_pend ? word_of(m_paddr[4:2], m_en, m_ie, m_pre, m_mt, m_cmp) : 32'd0;
      check("rand_hrdata", bus.HRDATA, exp);
      check("rand_irq", {31'd0, irq_timer}, {31'd0, m_irq});
    end
    hready_drv = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
